// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_bridge_pkg
//  Purpose  : Shared types, constants and helpers for the APB master bridge.
//  Revision : 1.0 - initial release
// ============================================================================
package apb_bridge_pkg;

    // Bridge transaction phases
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // READ_WRITE / pwrite encoding for a write transfer
    localparam logic RW_WRITE = 1'b1;

    // Width of the slave-select field; a single slave still needs one bit
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : apb_addr_decoder
//  Purpose  : Turns the slave-select field of an address into a one-hot PSEL
//             vector; an index with no slave behind it raises decode_err.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_addr_decoder
    import apb_bridge_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int SEL_W      = sel_w(NUM_SLAVES)
) (
    input  logic [SEL_W-1:0]      slave_idx,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  decode_err
);

    // One-hot select; indices at or above NUM_SLAVES leave every bit clear
    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slave_idx == SEL_W'(i)) begin
                psel[i] = 1'b1;
            end
        end
    end

    assign decode_err = ~|psel;

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge_n.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_bridge_n
//  Purpose  : APB master bridge towards NUM_SLAVES slaves. Converts user
//             requests into SETUP/ACCESS transfers with per-slave wait states,
//             back-to-back issue, an ACCESS timeout watchdog and decode-error
//             reporting. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge_n
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 2,
    parameter int SEL_W      = sel_w(NUM_SLAVES),
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             transfer,
    input  logic                             READ_WRITE,
    input  logic [ADDR_WIDTH-1:0]            apb_write_paddr,
    input  logic [ADDR_WIDTH-1:0]            apb_read_paddr,
    input  logic [DATA_WIDTH-1:0]            apb_write_data,
    output logic [DATA_WIDTH-1:0]            apb_read_data_out,
    output logic                             PSLVERR,
    output logic                             xfer_done,
    output logic                             busy,
    output logic [NUM_SLAVES-1:0]            m_psel,
    output logic                             m_penable,
    output logic                             m_pwrite,
    output logic [ADDR_WIDTH-1:0]            m_paddr,
    output logic [DATA_WIDTH-1:0]            m_pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
    input  logic [NUM_SLAVES-1:0]            m_pready,
    input  logic [NUM_SLAVES-1:0]            m_pslverr
);

    localparam int               CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e            r_state;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_dec_err;

    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [NUM_SLAVES-1:0] w_req_psel;
    logic                  w_req_dec_err;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_timeout;
    logic                  w_complete;
    logic                  w_err;
    logic                  w_capture;

    assign w_req_addr = (READ_WRITE == RW_WRITE) ? apb_write_paddr : apb_read_paddr;

    // The incoming request is decoded so PSEL is ready in the SETUP cycle
    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_W      (SEL_W)
    ) u_addr_decoder (
        .slave_idx  (w_req_addr[ADDR_WIDTH-1 -: SEL_W]),
        .psel       (w_req_psel),
        .decode_err (w_req_dec_err)
    );

    // Pick the response of the selected slave; others are masked by PSEL
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (m_psel[i]) begin
                w_sel_ready = m_pready[i];
                w_sel_err   = m_pslverr[i];
                w_sel_rdata = m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Timeout only fires on the last allowed cycle if the slave is still not ready
    assign w_timeout  = ~w_sel_ready & (r_wait_cnt == C_CNT_LAST);
    assign w_complete = w_sel_ready | r_dec_err | w_timeout;
    assign w_err      = w_sel_err | r_dec_err | w_timeout;
    assign w_capture  = transfer &
                        ((r_state == ST_IDLE) | ((r_state == ST_ACCESS) & w_complete));

    // Transfer sequencer, wait counter and all registered outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state           <= ST_IDLE;
            r_wait_cnt        <= '0;
            r_dec_err         <= 1'b0;
            m_psel            <= '0;
            m_penable         <= 1'b0;
            m_pwrite          <= 1'b0;
            m_paddr           <= '0;
            m_pwdata          <= '0;
            apb_read_data_out <= '0;
            PSLVERR           <= 1'b0;
            xfer_done         <= 1'b0;
            busy              <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            PSLVERR   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (transfer) begin
                        r_state <= ST_SETUP;
                        busy    <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    r_state    <= ST_ACCESS;
                    m_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                end

                ST_ACCESS: begin
                    if (w_complete) begin
                        xfer_done <= 1'b1;
                        PSLVERR   <= w_err;
                        m_penable <= 1'b0;
                        if (m_pwrite != RW_WRITE) begin
                            apb_read_data_out <= w_err ? '0 : w_sel_rdata;
                        end
                        if (transfer) begin
                            r_state <= ST_SETUP;
                        end else begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                            m_psel  <= '0;
                        end
                    end else if (r_wait_cnt != C_CNT_LAST) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    busy      <= 1'b0;
                    m_psel    <= '0;
                    m_penable <= 1'b0;
                end
            endcase

            // Holding registers double as the APB address/control/data outputs
            if (w_capture) begin
                m_psel    <= w_req_psel;
                r_dec_err <= w_req_dec_err;
                m_paddr   <= w_req_addr;
                m_pwrite  <= READ_WRITE;
                m_pwdata  <= apb_write_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_bridge_n
//  Purpose  : Self-checking bench for apb_master_bridge_n: directed vector
//             table, randomized transactions against a transaction-level
//             model, plus mid-transfer reset and decode-error sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge_n;

    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int NS  = 2;
    localparam int SW  = 1;
    localparam int TMO = 16;

    typedef struct {
        bit          wr;
        logic [8:0]  addr;
        logic [7:0]  wdata;
        int          wait_n;   // wait states the slave inserts before ready
        bit          slverr;   // slave error presented with ready
        logic [7:0]  rdata;    // slave read data presented with ready
        bit          b2b;      // issued back-to-back after the previous one
        int          gap;      // idle cycles after completion (non b2b)
        bit          exp_err;
        logic [7:0]  exp_rd;
        int          exp_acc;  // expected number of ACCESS cycles
    } txn_t;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic           transfer, READ_WRITE;
    logic [AW-1:0]  apb_write_paddr, apb_read_paddr;
    logic [DW-1:0]  apb_write_data, apb_read_data_out;
    logic           PSLVERR, xfer_done, busy, m_penable, m_pwrite;
    logic [NS-1:0]  m_psel, m_pready, m_pslverr;
    logic [AW-1:0]  m_paddr;
    logic [DW-1:0]  m_pwdata;
    logic [NS*DW-1:0] m_prdata;

    // Second instance with three slaves for the decode-error corner
    logic           t3_transfer, t3_rw;
    logic [AW-1:0]  t3_waddr, t3_raddr, t3_paddr;
    logic [DW-1:0]  t3_wdata, t3_rdout, t3_pwdata;
    logic           t3_pslverr_o, t3_done, t3_busy, t3_penable, t3_pwrite;
    logic [2:0]     t3_psel, t3_pready, t3_pslverr;
    logic [23:0]    t3_prdata;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_rd_now;
    txn_t seq[$];
    txn_t tbl[7];

    always #5 PCLK = ~PCLK;

    apb_master_bridge_n #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
        .apb_write_data(apb_write_data), .apb_read_data_out(apb_read_data_out),
        .PSLVERR(PSLVERR), .xfer_done(xfer_done), .busy(busy), .m_psel(m_psel),
        .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    apb_master_bridge_n #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(3), .TIMEOUT(TMO)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(t3_transfer), .READ_WRITE(t3_rw),
        .apb_write_paddr(t3_waddr), .apb_read_paddr(t3_raddr),
        .apb_write_data(t3_wdata), .apb_read_data_out(t3_rdout),
        .PSLVERR(t3_pslverr_o), .xfer_done(t3_done), .busy(t3_busy), .m_psel(t3_psel),
        .m_penable(t3_penable), .m_pwrite(t3_pwrite), .m_paddr(t3_paddr), .m_pwdata(t3_pwdata),
        .m_prdata(t3_prdata), .m_pready(t3_pready), .m_pslverr(t3_pslverr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    // Slave index is the top SW address bits
    function automatic int sel_idx(input logic [8:0] a);
        return int'(a >> (AW - SW));
    endfunction

    function automatic logic [1:0] exp_psel(input logic [8:0] a);
        return (sel_idx(a) < NS) ? 2'(1 << sel_idx(a)) : 2'b00;
    endfunction

    function automatic txn_t mk(input bit wr, input logic [8:0] a, input logic [7:0] wd,
                                input int w, input bit e, input logic [7:0] rd, input bit b2b,
                                input int gap, input bit xe, input logic [7:0] xrd, input int xacc);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = wd; t.wait_n = w; t.slverr = e; t.rdata = rd;
        t.b2b = b2b; t.gap = gap; t.exp_err = xe; t.exp_rd = xrd; t.exp_acc = xacc;
        return t;
    endfunction

    // Transaction-level reference: outcome from address, wait states and errors
    function automatic txn_t model(input txn_t t, input logic [7:0] prev_rd);
        bit dec, tmo;
        dec = sel_idx(t.addr) >= NS;
        tmo = !dec && (t.wait_n + 1 > TMO);
        t.exp_acc = dec ? 1 : (tmo ? TMO : t.wait_n + 1);
        t.exp_err = dec || tmo || t.slverr;
        t.exp_rd  = t.wr ? prev_rd : (t.exp_err ? 8'h00 : t.rdata);
        return t;
    endfunction

    task automatic drive_req(input txn_t t);
        transfer       = 1'b1;
        READ_WRITE     = t.wr;
        apb_write_data = t.wdata;
        if (t.wr) begin
            apb_write_paddr = t.addr;
            apb_read_paddr  = 9'($urandom);
        end else begin
            apb_read_paddr  = t.addr;
            apb_write_paddr = 9'($urandom);
        end
    endtask

    task automatic idle_req();
        transfer        = 1'b0;
        READ_WRITE      = 1'($urandom);
        apb_write_paddr = 9'($urandom);
        apb_read_paddr  = 9'($urandom);
        apb_write_data  = 8'($urandom);
    endtask

    task automatic rand_slaves();
        m_prdata  = 16'($urandom);
        m_pready  = 2'($urandom);
        m_pslverr = 2'($urandom);
    endtask

    task automatic chk_bus(input txn_t t, input bit en);
        chk("psel",    32'(m_psel),    32'(exp_psel(t.addr)));
        chk("penable", 32'(m_penable), 32'(en));
        chk("busy",    32'(busy),      32'd1);
        chk("paddr",   32'(m_paddr),   32'(t.addr));
        chk("pwrite",  32'(m_pwrite),  32'(t.wr));
        chk("pwdata",  32'(m_pwdata),  32'(t.wdata));
    endtask

    task automatic chk_idle(input bit done, input bit err);
        chk("idle_done",    32'(xfer_done),         32'(done));
        chk("idle_pslverr", 32'(PSLVERR),           32'(err));
        chk("idle_rdata",   32'(apb_read_data_out), 32'(exp_rd_now));
        chk("idle_psel",    32'(m_psel),            32'd0);
        chk("idle_penable", 32'(m_penable),         32'd0);
        chk("idle_busy",    32'(busy),              32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"},    32'(m_psel),            32'd0);
        chk({tag, "_penable"}, 32'(m_penable),         32'd0);
        chk({tag, "_pwrite"},  32'(m_pwrite),          32'd0);
        chk({tag, "_paddr"},   32'(m_paddr),           32'd0);
        chk({tag, "_pwdata"},  32'(m_pwdata),          32'd0);
        chk({tag, "_rdata"},   32'(apb_read_data_out), 32'd0);
        chk({tag, "_pslverr"}, 32'(PSLVERR),           32'd0);
        chk({tag, "_done"},    32'(xfer_done),         32'd0);
        chk({tag, "_busy"},    32'(busy),              32'd0);
    endtask

    // Applies every transaction in seq cycle by cycle; DUT must start IDLE
    task automatic run_seq();
        bit pend, perr, b2b;
        int idx;
        txn_t t;
        pend = 1'b0;
        perr = 1'b0;
        drive_req(seq[0]);
        rand_slaves();
        tick();
        for (int k = 0; k < seq.size(); k++) begin
            t   = seq[k];
            idx = sel_idx(t.addr);
            b2b = (k + 1 < seq.size()) && seq[k+1].b2b;
            // SETUP cycle (also the completion pulse of a back-to-back predecessor)
            chk("setup_done",    32'(xfer_done),         32'(pend));
            chk("setup_pslverr", 32'(PSLVERR),           32'(pend & perr));
            chk("setup_rdata",   32'(apb_read_data_out), 32'(exp_rd_now));
            chk_bus(t, 1'b0);
            pend = 1'b0;
            if (b2b) drive_req(seq[k+1]);
            else     idle_req();
            rand_slaves();
            tick();
            for (int a = 1; a <= t.exp_acc; a++) begin
                chk("acc_done",    32'(xfer_done),         32'd0);
                chk("acc_pslverr", 32'(PSLVERR),           32'd0);
                chk("acc_rdata",   32'(apb_read_data_out), 32'(exp_rd_now));
                chk_bus(t, 1'b1);
                rand_slaves();
                if (idx < NS) begin
                    if (a == t.wait_n + 1) begin
                        m_pready[idx]          = 1'b1;
                        m_pslverr[idx]         = t.slverr;
                        m_prdata[idx*DW +: DW] = t.rdata;
                    end else begin
                        m_pready[idx] = 1'b0;
                    end
                end
                tick();
            end
            exp_rd_now = t.exp_rd;
            if (b2b) begin
                pend = 1'b1;
                perr = t.exp_err;
            end else begin
                chk_idle(1'b1, t.exp_err);
                idle_req();
                rand_slaves();
                for (int g = 0; g < t.gap; g++) begin
                    tick();
                    chk_idle(1'b0, 1'b0);
                end
                if (k + 1 < seq.size()) begin
                    drive_req(seq[k+1]);
                    tick();
                end
            end
        end
    endtask

    initial begin
        txn_t t;
        logic [7:0] prev;
        PRESET = 1'b1;
        transfer = 1'b0; READ_WRITE = 1'b0; apb_write_paddr = '0; apb_read_paddr = '0;
        apb_write_data = '0; m_prdata = '0; m_pready = '0; m_pslverr = '0;
        t3_transfer = 1'b0; t3_rw = 1'b0; t3_waddr = '0; t3_raddr = '0; t3_wdata = '0;
        t3_prdata = '0; t3_pready = '0; t3_pslverr = '0;
        exp_rd_now = 8'h00;

        // Directed vectors: expectations written out by hand
        //            wr addr    wdata wait err rdata b2b gap  xerr xrd  xacc
        tbl[0] = mk(1, 9'h0AB, 8'h5C, 0,  0, 8'h11, 0, 1,  0, 8'h00, 1);
        tbl[1] = mk(0, 9'h1F0, 8'h21, 3,  0, 8'hA7, 0, 0,  0, 8'hA7, 4);
        tbl[2] = mk(0, 9'h010, 8'h33, 20, 0, 8'h77, 0, 2,  1, 8'h00, 16);
        tbl[3] = mk(1, 9'h005, 8'h3C, 0,  0, 8'h55, 0, 0,  0, 8'h00, 1);
        tbl[4] = mk(0, 9'h105, 8'h44, 1,  1, 8'h99, 1, 0,  1, 8'h00, 2);
        tbl[5] = mk(0, 9'h0FF, 8'h10, 0,  0, 8'h42, 0, 1,  0, 8'h42, 1);
        tbl[6] = mk(1, 9'h1AA, 8'h6E, 2,  1, 8'h00, 0, 0,  1, 8'h42, 3);

        @(negedge PCLK);
        tick();
        tick();
        chk_all_zero("reset");
        PRESET = 1'b0;
        tick();
        chk_all_zero("post_reset_idle");

        seq.delete();
        for (int i = 0; i < 7; i++) seq.push_back(tbl[i]);
        run_seq();

        // Randomized transactions checked against the reference model
        seq.delete();
        prev = exp_rd_now;
        for (int i = 0; i < 40; i++) begin
            t.wr     = 1'($urandom);
            t.addr   = 9'($urandom);
            t.wdata  = 8'($urandom);
            t.wait_n = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
            t.slverr = ($urandom_range(0, 3) == 0);
            t.rdata  = 8'($urandom);
            t.b2b    = 1'($urandom);
            t.gap    = int'($urandom_range(0, 2));
            t = model(t, prev);
            prev = t.exp_rd;
            seq.push_back(t);
        end
        run_seq();

        // Reset in the middle of an ACCESS phase
        t = mk(0, 9'h0C3, 8'h01, 5, 0, 8'hEE, 0, 0, 0, 8'h00, 6);
        drive_req(t);
        tick();
        idle_req();
        rand_slaves();
        m_pready[0] = 1'b0;
        tick();
        m_pready[0] = 1'b0;
        tick();
        chk("mid_penable", 32'(m_penable), 32'd1);
        PRESET = 1'b1;
        m_pready = '1;
        tick();
        chk_all_zero("mid_reset");
        PRESET = 1'b0;
        m_pready = '0;
        tick();
        exp_rd_now = 8'h00;
        chk_idle(1'b0, 1'b0);
        tick();
        chk_idle(1'b0, 1'b0);
        seq.delete();
        seq.push_back(mk(0, 9'h0C3, 8'h02, 0, 0, 8'h66, 0, 0, 0, 8'h66, 1));
        run_seq();

        // Decode error on the three-slave instance: index 3 has no slave
        t3_transfer = 1'b1; t3_raddr = 9'h1C0; t3_pready = '1; t3_prdata = '1; t3_pslverr = '0;
        tick();
        t3_transfer = 1'b0;
        chk("dec_setup_psel",  32'(t3_psel),    32'd0);
        chk("dec_setup_busy",  32'(t3_busy),    32'd1);
        chk("dec_setup_pen",   32'(t3_penable), 32'd0);
        tick();
        chk("dec_acc_psel",    32'(t3_psel),    32'd0);
        chk("dec_acc_pen",     32'(t3_penable), 32'd1);
        chk("dec_acc_done",    32'(t3_done),    32'd0);
        tick();
        chk("dec_done",        32'(t3_done),      32'd1);
        chk("dec_pslverr",     32'(t3_pslverr_o), 32'd1);
        chk("dec_rdata",       32'(t3_rdout),     32'd0);
        chk("dec_busy",        32'(t3_busy),      32'd0);
        tick();
        chk("dec_done_clear",  32'(t3_done),      32'd0);
        chk("dec_err_clear",   32'(t3_pslverr_o), 32'd0);

        // Valid read of slave 2 on the same instance
        t3_transfer = 1'b1; t3_raddr = 9'h100; t3_pready = 3'b100; t3_prdata = 24'h5AFFFF;
        tick();
        t3_transfer = 1'b0;
        chk("s2_psel",    32'(t3_psel),    32'h4);
        tick();
        chk("s2_pen",     32'(t3_penable), 32'd1);
        tick();
        chk("s2_done",    32'(t3_done),      32'd1);
        chk("s2_pslverr", 32'(t3_pslverr_o), 32'd0);
        chk("s2_rdata",   32'(t3_rdout),     32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
